// File: rtl/pwm_timer_core.sv
// PWM / timer consumer of the main counter bus: shadowed-duty PWM output,
// match-driven sticky interrupt and the one-shot re-arm pulse to main_counter.
module pwm_timer_core #(
  parameter int   WIDTH   = 16,
  parameter logic OUT_POL = 1'b1
) (
  input  logic             slow_clk,
  input  logic             rst,
  input  logic             sw_rst,
  input  logic [WIDTH-1:0] counter,
  input  logic             counter_en,
  input  logic             mode,
  input  logic             timer_mode,
  input  logic             irq_en,
  input  logic             out_en,
  input  logic [WIDTH-1:0] period_reg,
  input  logic [WIDTH-1:0] duty_reg,
  input  logic             irq_clr,
  output logic             pwm_out,
  output logic             irq,
  output logic             timer_done,
  output logic             irq_rst
);

  typedef enum logic [1:0] {IDLE, PWM_RUN, TIM_RUN, TIM_DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] duty_shadow;
  logic [WIDTH-1:0] last_count;
  logic             match, irq_set, irq_cleared, shadow_load, pwm_next;

  // Wraps to all-ones for period_reg=0, so the shadow never reloads there.
  assign last_count = period_reg - {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    match       = (state == TIM_RUN) && (counter == period_reg) && (period_reg != '0);
    irq_set     = match && irq_en;
    irq_cleared = irq_clr && irq && !irq_set;
    shadow_load = (state == IDLE) || ((state == PWM_RUN) && (counter == last_count));

    pwm_next = ~OUT_POL;
    if ((state == PWM_RUN) && out_en && (period_reg != '0) && (counter < duty_shadow))
      pwm_next = OUT_POL;

    // A mode flip while enabled always drops to IDLE for one cycle first.
    state_next = state;
    if (!counter_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     state_next = mode ? PWM_RUN : TIM_RUN;
        PWM_RUN:  if (!mode) state_next = IDLE;
        TIM_RUN: begin
          if (mode)                          state_next = IDLE;
          else if (match && !timer_mode)     state_next = TIM_DONE;
        end
        TIM_DONE: begin
          if (mode)                          state_next = IDLE;
          else if (irq_cleared || timer_mode) state_next = TIM_RUN;
        end
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge slow_clk) begin
    if (rst || sw_rst) begin
      state       <= IDLE;
      duty_shadow <= '0;
      pwm_out     <= ~OUT_POL;
      irq         <= 1'b0;
      timer_done  <= 1'b0;
      irq_rst     <= 1'b0;
    end else begin
      state   <= state_next;
      pwm_out <= pwm_next;
      if (shadow_load)
        duty_shadow <= duty_reg;
      // A set in the same cycle as a clear wins so no event is lost.
      if (irq_set)
        irq <= 1'b1;
      else if (irq_clr)
        irq <= 1'b0;
      timer_done <= (state_next == TIM_DONE);
      irq_rst    <= (state == TIM_DONE) && irq_cleared;
    end
  end

endmodule

// File: tb/tb_pwm_timer_core.sv
// Randomised + directed bench for pwm_timer_core: a rule-level reference model
// is compared against the DUT every cycle, with literal checks pinning the model.
module tb_pwm_timer_core;

  localparam int   W       = 16;
  localparam logic OUT_POL = 1'b1;
  localparam int   P_IDLE = 0, P_PWM = 1, P_TIM = 2, P_DONE = 3;

  logic         slow_clk = 1'b0;
  logic         rst, sw_rst, counter_en, mode, timer_mode, irq_en, out_en, irq_clr;
  logic [W-1:0] counter, period_reg, duty_reg;
  logic         pwm_out, irq, timer_done, irq_rst;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   checking = 1'b0;
  bit   auto_cnt = 1'b1;
  logic s_pwm, s_irq, s_done, s_rst;

  int           m_phase;
  logic [W-1:0] m_shadow;
  logic         m_pwm, m_irq, m_done, m_rst;

  pwm_timer_core #(.WIDTH(W), .OUT_POL(OUT_POL)) dut (
    .slow_clk  (slow_clk),
    .rst       (rst),
    .sw_rst    (sw_rst),
    .counter   (counter),
    .counter_en(counter_en),
    .mode      (mode),
    .timer_mode(timer_mode),
    .irq_en    (irq_en),
    .out_en    (out_en),
    .period_reg(period_reg),
    .duty_reg  (duty_reg),
    .irq_clr   (irq_clr),
    .pwm_out   (pwm_out),
    .irq       (irq),
    .timer_done(timer_done),
    .irq_rst   (irq_rst)
  );

  always #5 slow_clk = ~slow_clk;

  // Reference: evaluates the written rules directly from the inputs seen at each edge.
  always @(posedge slow_clk) begin : ref_model
    logic         hit, cleared;
    logic [W-1:0] last;
    if (rst || sw_rst) begin
      m_phase = P_IDLE; m_shadow = '0; m_pwm = ~OUT_POL;
      m_irq = 1'b0; m_done = 1'b0; m_rst = 1'b0;
    end else begin
      last    = period_reg - 16'd1;
      hit     = (m_phase == P_TIM) && (counter == period_reg) && (period_reg != 0);
      cleared = irq_clr && m_irq && !(hit && irq_en);
      m_rst   = (m_phase == P_DONE) && cleared;
      m_pwm   = (m_phase == P_PWM && out_en && period_reg != 0 && counter < m_shadow)
                ? OUT_POL : ~OUT_POL;
      if (m_phase == P_IDLE || (m_phase == P_PWM && counter == last))
        m_shadow = duty_reg;
      if (hit && irq_en) m_irq = 1'b1;
      else if (irq_clr)  m_irq = 1'b0;
      if (!counter_en) m_phase = P_IDLE;
      else if (m_phase == P_IDLE) m_phase = mode ? P_PWM : P_TIM;
      else if (m_phase == P_PWM) m_phase = mode ? P_PWM : P_IDLE;
      else if (m_phase == P_TIM) m_phase = mode ? P_IDLE : ((hit && !timer_mode) ? P_DONE : P_TIM);
      else m_phase = mode ? P_IDLE : ((cleared || timer_mode) ? P_TIM : P_DONE);
      m_done = (m_phase == P_DONE);
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s (cycle %0d): got %0d, want %0d", name, cyc, got, want);
    end
  endtask

  always @(negedge slow_clk) begin
    if (checking) begin
      check_output("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
      check_output("irq", {31'd0, irq}, {31'd0, m_irq});
      check_output("timer_done", {31'd0, timer_done}, {31'd0, m_done});
      check_output("irq_rst", {31'd0, irq_rst}, {31'd0, m_rst});
    end
  end

  // Samples outputs, then advances the counter the way main_counter would.
  task automatic step();
    @(negedge slow_clk);
    s_pwm = pwm_out; s_irq = irq; s_done = timer_done; s_rst = irq_rst;
    cyc++;
    if (!auto_cnt)
      counter = 16'($urandom_range(0, 7));
    else if (!counter_en)
      counter = '0;
    else if (mode)
      counter = (period_reg == 0 || counter >= period_reg - 16'd1) ? 16'd0 : counter + 16'd1;
    else if (m_rst || m_done)
      counter = '0;
    else
      counter = (counter >= period_reg) ? 16'd0 : counter + 16'd1;
  endtask

  task automatic wait_for(input int sel, input int limit, input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (((sel == 0) ? s_irq : s_done) !== 1'b1 && n < limit);
    check_output(name, {31'd0, (sel == 0) ? s_irq : s_done}, 32'd1);
  endtask

  task automatic apply_random_stimulus();
    rst    = ($urandom_range(0, 99) == 0);
    sw_rst = ($urandom_range(0, 99) == 0);
    counter_en = ($urandom_range(0, 15) != 0);
    if ($urandom_range(0, 39) == 0) mode = ~mode;
    if ($urandom_range(0, 29) == 0) timer_mode = ~timer_mode;
    if ($urandom_range(0, 99) == 0) auto_cnt = ~auto_cnt;
    irq_en  = ($urandom_range(0, 3) != 0);
    out_en  = ($urandom_range(0, 7) != 0);
    irq_clr = ($urandom_range(0, 5) == 0);
    if ($urandom_range(0, 29) == 0) period_reg = 16'($urandom_range(0, 6));
    if ($urandom_range(0, 9) == 0)  duty_reg   = 16'($urandom_range(0, 8));
  endtask

  initial begin
    int n, a, b;
    int duties[5] = '{1, 3, 0, 4, 9};
    int highs[5]  = '{2, 6, 0, 8, 8};
    rst = 1'b1; sw_rst = 1'b0; counter_en = 1'b0; mode = 1'b0; timer_mode = 1'b0;
    irq_en = 1'b0; out_en = 1'b0; irq_clr = 1'b0; counter = '0;
    period_reg = 16'd4; duty_reg = '0;
    step(); step();
    checking = 1'b1;
    check_output("reset pwm_out", {31'd0, s_pwm}, 32'd0);
    check_output("reset irq", {31'd0, s_irq}, 32'd0);
    check_output("reset timer_done", {31'd0, s_done}, 32'd0);
    rst = 1'b0;

    // PWM duty sweep at period 4: active cycles in an 8-cycle window.
    mode = 1'b1; out_en = 1'b1; counter_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      duty_reg = 16'(duties[i]);
      repeat (10) step();
      a = 0;
      repeat (8) begin step(); a += int'(s_pwm); end
      check_output($sformatf("pwm high count duty=%0d", duties[i]), 32'(a), 32'(highs[i]));
    end

    duty_reg = 16'd3;
    repeat (6) step();
    rst = 1'b1; step(); rst = 1'b0;
    check_output("rst pwm_out", {31'd0, s_pwm}, 32'd0);
    check_output("rst irq_rst", {31'd0, s_rst}, 32'd0);
    repeat (6) step();
    sw_rst = 1'b1; step(); sw_rst = 1'b0;
    check_output("sw_rst pwm_out", {31'd0, s_pwm}, 32'd0);

    // Duty 2 -> 7 written at counter=4 of a period-10 cycle.
    period_reg = 16'd10; duty_reg = 16'd2; counter_en = 1'b0;
    step();
    counter_en = 1'b1;
    repeat (12) step();
    n = 0;
    do begin step(); n++; end while (counter != 16'd4 && n < 30);
    check_output("reach counter 4", 32'(counter), 32'd4);
    duty_reg = 16'd7;
    a = 0; b = 0;
    repeat (6)  begin step(); a += int'(s_pwm); end
    repeat (10) begin step(); b += int'(s_pwm); end
    check_output("old duty rest of cycle", 32'(a), 32'd0);
    check_output("new duty next cycle", 32'(b), 32'd7);

    // Continuous timer, period 4.
    counter_en = 1'b0; mode = 1'b0; timer_mode = 1'b1; irq_en = 1'b1;
    period_reg = 16'd4; irq_clr = 1'b1;
    step();
    irq_clr = 1'b0; counter_en = 1'b1;
    wait_for(0, 20, "cont first irq", n);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check_output("cont irq cleared", {31'd0, s_irq}, 32'd0);
    wait_for(0, 20, "cont second irq", n);
    check_output("cont irq spacing", 32'(n), 32'd4);
    check_output("cont no timer_done", {31'd0, s_done}, 32'd0);
    repeat (4) step();
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check_output("clr vs set irq", {31'd0, s_irq}, 32'd1);

    // One-shot timer, period 4.
    counter_en = 1'b0; irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check_output("idle clr irq", {31'd0, s_irq}, 32'd0);
    timer_mode = 1'b0; counter_en = 1'b1;
    wait_for(0, 20, "oneshot irq", n);
    check_output("oneshot timer_done", {31'd0, s_done}, 32'd1);
    repeat (10) step();
    check_output("oneshot held done", {31'd0, s_done}, 32'd1);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check_output("rearm irq_rst", {31'd0, s_rst}, 32'd1);
    check_output("rearm timer_done", {31'd0, s_done}, 32'd0);
    wait_for(0, 20, "rearm irq", n);
    check_output("rearm match delay", 32'(n), 32'd5);

    counter_en = 1'b0; step();
    check_output("disable done clears", {31'd0, s_done}, 32'd0);
    check_output("disable irq held", {31'd0, s_irq}, 32'd1);

    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    irq_en = 1'b0; counter_en = 1'b1;
    wait_for(1, 20, "no-irq timer_done", n);
    check_output("irq_en=0 irq low", {31'd0, s_irq}, 32'd0);

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      apply_random_stimulus();
      step();
    end
    rst = 1'b0; sw_rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
